// File: rtl/huffman_table_builder.sv
// Front end of the Huffman accelerator: per-lane symbol/frequency table, sorted by an odd-even
// transposition network on ctrl_start. Optional macro TABLE_CLEAR_ON_DONE_EN clears the table after DONE.
module huffman_table_builder #(
  parameter int N_LANES = 6,
  parameter int SYM_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_LANES-1:0]         ctrl_wrAscii,
  input  logic [N_LANES*SYM_W-1:0]   wrAscii,
  input  logic                       ctrl_start,
  output logic                       busy,
  output logic                       done,
  output logic [N_LANES*SYM_W-1:0]   tbl_sym,
  output logic [N_LANES*CNT_W-1:0]   tbl_cnt,
  output logic [N_LANES-1:0]         tbl_valid
);

  localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [PW-1:0] PASS_LAST = PW'(N_LANES - 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                            state_q, state_d;
  logic [PW-1:0]                     pass_q, pass_d;
  logic [N_LANES-1:0][SYM_W-1:0]     sym_q, sym_d;
  logic [N_LANES-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_LANES-1:0]                vld_q, vld_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Invalid entries sink to the end; ties on count go to the lower symbol code.
  function automatic logic right_wins(input logic vl, input logic [CNT_W-1:0] cl,
                                      input logic [SYM_W-1:0] sl, input logic vr,
                                      input logic [CNT_W-1:0] cr, input logic [SYM_W-1:0] sr);
    if (!vr) return 1'b0;
    if (!vl) return 1'b1;
    if (cr != cl) return cr > cl;
    return sr < sl;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (ctrl_start) begin
        state_d = SORT;
        pass_d  = '0;
      end
      SORT: begin
        if (pass_q == PASS_LAST) state_d = DONE;
        else                     pass_d  = pass_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SORT);
    done = (state_q == DONE);
  end

  // Even passes compare pairs starting at entry 0, odd passes at entry 1; pairs never overlap.
  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < N_LANES; i++) begin
          if (ctrl_wrAscii[i]) begin
            sym_d[i] = wrAscii[i*SYM_W +: SYM_W];
            cnt_d[i] = sat_inc(cnt_q[i]);
            vld_d[i] = 1'b1;
          end
        end
      end
      SORT: begin
        for (int i = 0; i < N_LANES - 1; i++) begin
          if ((i[0] == pass_q[0]) &&
              right_wins(vld_q[i], cnt_q[i], sym_q[i], vld_q[i+1], cnt_q[i+1], sym_q[i+1])) begin
            sym_d[i]   = sym_q[i+1];
            cnt_d[i]   = cnt_q[i+1];
            vld_d[i]   = vld_q[i+1];
            sym_d[i+1] = sym_q[i];
            cnt_d[i+1] = cnt_q[i];
            vld_d[i+1] = vld_q[i];
          end
        end
      end
      DONE: begin
`ifdef TABLE_CLEAR_ON_DONE_EN
        sym_d = '0;
        cnt_d = '0;
        vld_d = '0;
`else
        vld_d = vld_q;
`endif
      end
      default: vld_d = vld_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_q <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign tbl_sym   = sym_q;
  assign tbl_cnt   = cnt_q;
  assign tbl_valid = vld_q;

endmodule

// File: tb/tb_huffman_table_builder.sv
// Self-checking bench for huffman_table_builder: vector table of write patterns with expected
// sorted tables, scoreboard popped on done, plus reset-abort, held-start and post-sort write sequences.
module tb_huffman_table_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ctrl_wrAscii;
  logic [47:0] wrAscii;
  logic        ctrl_start;
  logic        busy, done;
  logic [47:0] tbl_sym, tbl_cnt;
  logic [5:0]  tbl_valid;

  huffman_table_builder #(.N_LANES(6), .SYM_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ctrl_wrAscii(ctrl_wrAscii), .wrAscii(wrAscii),
    .ctrl_start(ctrl_start), .busy(busy), .done(done),
    .tbl_sym(tbl_sym), .tbl_cnt(tbl_cnt), .tbl_valid(tbl_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][7:0] sym;
    logic [5:0][8:0] nwr;
    logic            wr_sort;
    logic [5:0][7:0] exp_sym;
    logic [5:0][7:0] exp_cnt;
    logic [5:0]      exp_vld;
  } vec_t;

  typedef struct packed {
    logic [47:0] sym;
    logic [47:0] cnt;
    logic [5:0]  vld;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ctrl_wrAscii = '0;
    wrAscii      = '0;
    ctrl_start   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   maxw;
    int   lat;
    int   nb;
    bit   got;
    exp_t e;
    do_reset();
    maxw = 0;
    for (int i = 0; i < 6; i++) if (int'(v.nwr[i]) > maxw) maxw = int'(v.nwr[i]);
    for (int k = 0; k < maxw; k++) begin
      for (int i = 0; i < 6; i++) begin
        ctrl_wrAscii[i]   = (int'(v.nwr[i]) > k);
        wrAscii[i*8 +: 8] = v.sym[i];
      end
      ctrl_start = (k == maxw - 1);
      if (ctrl_start) sb_q.push_back('{sym: v.exp_sym, cnt: v.exp_cnt, vld: v.exp_vld});
      tick();
    end
    ctrl_start   = 1'b0;
    ctrl_wrAscii = v.wr_sort ? 6'h3F : 6'h00;
    wrAscii      = {6{8'hEE}};
    lat = 1;
    nb  = 0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nb++;
      tick();
      lat++;
    end
    ctrl_wrAscii = '0;
    if (!got) begin
      check($sformatf("v%0d_done_timeout", idx), 48'd0, 48'd1);
    end else begin
      check($sformatf("v%0d_latency", idx), 48'(lat), 48'd7);
      check($sformatf("v%0d_busy_cycles", idx), 48'(nb), 48'd6);
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_sb_empty", idx), 48'd0, 48'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_sym", idx), tbl_sym, e.sym);
        check($sformatf("v%0d_cnt", idx), tbl_cnt, e.cnt);
        check($sformatf("v%0d_vld", idx), 48'(tbl_valid), 48'(e.vld));
        tick();
`ifdef TABLE_CLEAR_ON_DONE_EN
        check($sformatf("v%0d_after_cnt", idx), tbl_cnt, 48'd0);
`else
        check($sformatf("v%0d_after_cnt", idx), tbl_cnt, e.cnt);
`endif
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0, d1, ndone;
    bit  saw_done;

    vecs[0].sym = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[0].nwr = {6{9'd1}};
    vecs[0].wr_sort = 1'b0;
    vecs[0].exp_sym = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[0].exp_cnt = {6{8'd1}};
    vecs[0].exp_vld = 6'h3F;

    vecs[1].sym = {8'h00, 8'h41, 8'h00, 8'h00, 8'h42, 8'h43};
    vecs[1].nwr = {9'd0, 9'd3, 9'd0, 9'd0, 9'd2, 9'd1};
    vecs[1].wr_sort = 1'b0;
    vecs[1].exp_sym = {8'h00, 8'h00, 8'h00, 8'h43, 8'h42, 8'h41};
    vecs[1].exp_cnt = {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    vecs[1].exp_vld = 6'b000111;

    vecs[2].sym = {6{8'h20}};
    vecs[2].nwr = {6{9'd1}};
    vecs[2].wr_sort = 1'b0;
    vecs[2].exp_sym = {6{8'h20}};
    vecs[2].exp_cnt = {6{8'd1}};
    vecs[2].exp_vld = 6'h3F;

    vecs[3].sym = {8'h63, 8'h62, 8'h00, 8'h61, 8'h30, 8'h7A};
    vecs[3].nwr = {9'd2, 9'd4, 9'd0, 9'd1, 9'd2, 9'd2};
    vecs[3].wr_sort = 1'b0;
    vecs[3].exp_sym = {8'h00, 8'h61, 8'h7A, 8'h63, 8'h30, 8'h62};
    vecs[3].exp_cnt = {8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd4};
    vecs[3].exp_vld = 6'h1F;

    vecs[4].sym = {8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00};
    vecs[4].nwr = {9'd0, 9'd0, 9'd0, 9'd300, 9'd0, 9'd0};
    vecs[4].wr_sort = 1'b1;
    vecs[4].exp_sym = {40'h0, 8'h5A};
    vecs[4].exp_cnt = {40'h0, 8'hFF};
    vecs[4].exp_vld = 6'h01;

    // Reset state
    do_reset();
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_sym", tbl_sym, 48'd0);
    check("rst_cnt", tbl_cnt, 48'd0);
    check("rst_vld", 48'(tbl_valid), 48'd0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

    // Reset during pass 3 aborts the sort silently
    do_reset();
    ctrl_wrAscii = 6'h3F;
    wrAscii      = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    ctrl_start   = 1'b1;
    tick();
    ctrl_wrAscii = '0;
    ctrl_start   = 1'b0;
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 48'(busy), 48'd0);
    check("abort_done", 48'(done), 48'd0);
    check("abort_sym", tbl_sym, 48'd0);
    check("abort_cnt", tbl_cnt, 48'd0);
    check("abort_vld", 48'(tbl_valid), 48'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", 48'(saw_done), 48'd0);

    // Writes after a sort land in sorted slots by lane index
    run_vec(vecs[1], 5);
    ctrl_wrAscii = 6'h01;
    wrAscii      = {40'h0, 8'h55};
    tick();
    ctrl_wrAscii = '0;
    check("post_sym0", 48'(tbl_sym[7:0]), 48'h55);
`ifdef TABLE_CLEAR_ON_DONE_EN
    check("post_cnt", tbl_cnt, 48'd1);
    check("post_vld", 48'(tbl_valid), 48'h01);
`else
    check("post_cnt", tbl_cnt, {40'h0102, 8'd4});
    check("post_vld", 48'(tbl_valid), 48'h07);
`endif

    // Held ctrl_start: back-to-back sorts
    do_reset();
    ctrl_wrAscii = 6'h01;
    wrAscii      = {40'h0, 8'h10};
    ctrl_start   = 1'b1;
    tick();
    ctrl_wrAscii = '0;
    d0 = -1;
    d1 = -1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        if (ndone == 0) d0 = c;
        else if (ndone == 1) d1 = c;
        ndone++;
`ifdef TABLE_CLEAR_ON_DONE_EN
        tick();
        check("held_clear_cnt", tbl_cnt, 48'd0);
        continue;
`endif
      end
      tick();
    end
    ctrl_start = 1'b0;
    check("held_two_dones", 48'(ndone >= 2), 48'd1);
    check("held_period", 48'(d1 - d0), 48'd8);
    for (int c = 0; c < 10; c++) tick();
    check("held_idle", 48'(busy), 48'd0);
`ifdef TABLE_CLEAR_ON_DONE_EN
    check("held_final_cnt", tbl_cnt, 48'd0);
`else
    check("held_final_cnt", tbl_cnt, 48'd1);
    check("held_final_sym", tbl_sym, 48'h10);
`endif

    check("sb_drained", 48'(sb_q.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
